// File: rtl/ks_pkg.sv
// rtl/ks_pkg.sv - shared types and propagate/generate helper for the Kogge-Stone adder
package ks_pkg;

    localparam int KS_WIDTH = 32;

    typedef struct packed {
        logic [KS_WIDTH-1:0] p;
        logic [KS_WIDTH-1:0] g;
        logic                cin;
    } pg_beat_t;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_FULL1,
        OCC_FULL2
    } occ_state_t;

    // cin folds into g[0] only, so level 1 never needs a separate carry input
    function automatic pg_beat_t pg_gen(input logic [KS_WIDTH-1:0] a,
                                        input logic [KS_WIDTH-1:0] b,
                                        input logic                cin);
        pg_beat_t r;
        r.p    = a ^ b;
        r.g    = a & b;
        r.g[0] = r.g[0] | (r.p[0] & cin);
        r.cin  = cin;
        return r;
    endfunction

endpackage

// File: rtl/ks_pg_stage_if.sv
// rtl/ks_pg_stage_if.sv - operand and p/g handshake bundle; in_sub exists only with KS_PG_SUB_EN
interface ks_pg_stage_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
`ifdef KS_PG_SUB_EN
    logic             in_sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] p_list0;
    logic [WIDTH-1:0] g_list0;
    logic             cin_q;
    logic [CNT_W-1:0] op_count;

    modport master (
`ifdef KS_PG_SUB_EN
        output in_sub,
`endif
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, p_list0, g_list0, cin_q, op_count
    );

    modport slave (
`ifdef KS_PG_SUB_EN
        input  in_sub,
`endif
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, p_list0, g_list0, cin_q, op_count
    );

endinterface

// File: rtl/ks_skid_buf.sv
// rtl/ks_skid_buf.sv - generic 2-entry valid/ready skid register with registered in_ready
module ks_skid_buf
    import ks_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    occ_state_t   state;
    logic [W-1:0] skid_data;
    logic         accept;
    logic         emit;

    assign accept = in_valid & in_ready;
    assign emit   = out_valid & out_ready;

    // in_ready is low during reset and rises on the first edge after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= OCC_EMPTY;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            skid_data <= '0;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        out_data  <= in_data;
                        out_valid <= 1'b1;
                        state     <= OCC_FULL1;
                    end
                end
                OCC_FULL1: begin
                    if (accept && emit) begin
                        out_data <= in_data;
                    end else if (accept) begin
                        skid_data <= in_data;
                        in_ready  <= 1'b0;
                        state     <= OCC_FULL2;
                    end else if (emit) begin
                        out_valid <= 1'b0;
                        state     <= OCC_EMPTY;
                    end
                end
                OCC_FULL2: begin
                    if (emit) begin
                        out_data <= skid_data;
                        in_ready <= 1'b1;
                        state    <= OCC_FULL1;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= OCC_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/ks_pg_stage.sv
// rtl/ks_pg_stage.sv - registered p/g front end of the 32-bit Kogge-Stone adder
// Optional subtract mode (in_sub) is enabled by defining KS_PG_SUB_EN.
module ks_pg_stage
    import ks_pkg::*;
#(
    parameter int WIDTH = KS_WIDTH,
    parameter int CNT_W = 16
) (
    input logic         clk,
    input logic         rst_n,
    ks_pg_stage_if.slave bus
);

    localparam int PW = 2 * WIDTH + 1;

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    pg_beat_t         beat;
    logic [PW-1:0]    in_payload;
    logic [PW-1:0]    out_payload;

`ifdef KS_PG_SUB_EN
    // A - B = A + ~B + 1; cin_q carries the effective carry-in to the sum stage
    assign b_eff   = bus.in_sub ? ~bus.in_b : bus.in_b;
    assign cin_eff = bus.in_sub | bus.in_cin;
`else
    assign b_eff   = bus.in_b;
    assign cin_eff = bus.in_cin;
`endif

    assign beat       = pg_gen(KS_WIDTH'(bus.in_a), KS_WIDTH'(b_eff), cin_eff);
    assign in_payload = {beat.p[WIDTH-1:0], beat.g[WIDTH-1:0], beat.cin};

    ks_skid_buf #(
        .W(PW)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (in_payload),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (out_payload)
    );

    assign bus.p_list0 = out_payload[PW-1 -: WIDTH];
    assign bus.g_list0 = out_payload[WIDTH -: WIDTH];
    assign bus.cin_q   = out_payload[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.op_count <= '0;
        end else if (bus.in_valid && bus.in_ready) begin
            bus.op_count <= bus.op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ks_pg_stage.sv
// tb/tb_ks_pg_stage.sv - self-checking bench for ks_pg_stage; subtract checks need KS_PG_SUB_EN
module tb_ks_pg_stage;

    logic clk;
    logic rst_n;

    ks_pg_stage_if #(.WIDTH(32), .CNT_W(16)) bus ();
    ks_pg_stage_if #(.WIDTH(32), .CNT_W(4))  bus4 ();

    ks_pg_stage #(.WIDTH(32), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    ks_pg_stage #(.WIDTH(32), .CNT_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
    } exp_t;

    exp_t        q[$];
    logic [31:0] emitted[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          model_cnt = 0;
    int          n_emit   = 0;
    int          cyc      = 0;
    bit          logging  = 0;
    bit          ready_ok = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ripple carry over the DUT's p/g, standing in for the prefix tree + sum stage
    function automatic logic [31:0] pg_sum(input logic [31:0] p, input logic [31:0] g, input logic cin);
        logic        c;
        logic [31:0] s;
        c = cin;
        for (int i = 0; i < 32; i++) begin
            s[i] = p[i] ^ c;
            c    = g[i] | (p[i] & c);
        end
        return s;
    endfunction

    always @(posedge clk) cyc++;
    always @(posedge clk or negedge rst_n) ready_ok = rst_n;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            model_cnt = 0;
        end else begin
            chk("out_valid", bus.out_valid, q.size() != 0);
            chk("in_ready", bus.in_ready, ready_ok && q.size() < 2);
            chk("op_count", bus.op_count, 16'(model_cnt));
            if (bus.out_valid && q.size() > 0) begin
                exp_t        e;
                logic [31:0] eg;
                logic [31:0] esum;
                e     = q[0];
                eg    = e.a & e.b;
                eg[0] = (32'(e.a[0]) + 32'(e.b[0]) + 32'(e.cin)) > 1;
                esum  = e.a + e.b + 32'(e.cin);
                chk("p_list0", bus.p_list0, e.a ^ e.b);
                chk("g_list0", bus.g_list0, eg);
                chk("cin_q", bus.cin_q, e.cin);
                chk("sum", pg_sum(bus.p_list0, bus.g_list0, bus.cin_q), esum);
                if (bus.out_ready) begin
                    if (logging) emitted.push_back(bus.p_list0);
                    n_emit++;
                    void'(q.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_t n;
                n.a   = bus.in_a;
                n.b   = bus.in_b;
                n.cin = bus.in_cin;
`ifdef KS_PG_SUB_EN
                if (bus.in_sub) begin
                    n.b   = ~bus.in_b;
                    n.cin = 1'b1;
                end
`endif
                q.push_back(n);
                model_cnt++;
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin);
        bit acc;
        int n;
        acc = 0;
        n   = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        chk("accept_timeout", acc, 1'b1);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int emit0;
        int cyc0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b0;
        bus4.in_valid  = 1'b0;
        bus4.in_a      = 32'h1234;
        bus4.in_b      = 32'h1;
        bus4.in_cin    = 1'b0;
        bus4.out_ready = 1'b1;
`ifdef KS_PG_SUB_EN
        bus.in_sub  = 1'b0;
        bus4.in_sub = 1'b0;
`endif
        tick(3);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_p", bus.p_list0, 0);
        chk("rst_g", bus.g_list0, 0);
        chk("rst_cin_q", bus.cin_q, 0);
        chk("rst_op_count", bus.op_count, 0);
        rst_n = 1'b1;
        tick(1);
        chk("ready_after_rst", bus.in_ready, 1);

        // single beat
        bus.out_ready = 1'b1;
        send(32'h0000_00FF, 32'h0000_0001, 1'b0);
        bus.in_valid = 1'b0;
        chk("single_valid", bus.out_valid, 1);
        chk("single_p", bus.p_list0, 32'h0000_00FE);
        chk("single_g", bus.g_list0, 32'h0000_0001);
        chk("single_cnt", bus.op_count, 1);
        chk("single_sum", pg_sum(bus.p_list0, bus.g_list0, bus.cin_q), 32'h0000_0100);

        // carry-in fold
        send(32'h1, 32'h0, 1'b1);
        bus.in_valid = 1'b0;
        chk("fold_g", bus.g_list0, 32'h1);
        chk("fold_p", bus.p_list0, 32'h1);
        chk("fold_cin_q", bus.cin_q, 1);
        send(32'h0, 32'h0, 1'b1);
        bus.in_valid = 1'b0;
        chk("fold0_g", bus.g_list0, 32'h0);
        chk("fold0_cin_q", bus.cin_q, 1);
        tick(1);

        // backpressure
        bus.out_ready = 1'b0;
        logging = 1;
        emitted.delete();
        send(32'h10, 32'h0, 1'b0);
        send(32'h11, 32'h0, 1'b0);
        bus.in_a = 32'h12;
        tick(3);
        chk("bp_in_ready", bus.in_ready, 0);
        chk("bp_hold_p", bus.p_list0, 32'h10);
        chk("bp_cnt", bus.op_count, 5);
        bus.out_ready = 1'b1;
        send(32'h12, 32'h0, 1'b0);
        bus.in_valid = 1'b0;
        tick(3);
        logging = 0;
        chk("bp_n_out", emitted.size(), 3);
        for (int i = 0; i < 3 && i < emitted.size(); i++)
            chk("bp_order", emitted[i], 32'h10 + 32'(i));
        chk("bp_cnt_end", bus.op_count, 6);

        // async reset while FULL2
        bus.out_ready = 1'b0;
        send(32'h20, 32'h0, 1'b0);
        send(32'h21, 32'h0, 1'b0);
        bus.in_valid = 1'b0;
        emit0 = n_emit;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_in_ready", bus.in_ready, 0);
        chk("arst_cnt", bus.op_count, 0);
        tick(1);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick(4);
        chk("arst_ready_after", bus.in_ready, 1);
        chk("arst_no_stale", n_emit - emit0, 0);

        // full throughput
        emit0 = n_emit;
        cyc0  = cyc;
        for (int i = 0; i < 1000; i++)
            send($urandom, $urandom, 1'($urandom_range(0, 1)));
        bus.in_valid = 1'b0;
        chk("tp_cycles", cyc - cyc0, 1000);
        chk("tp_cnt", bus.op_count, 1000);
        tick(1);
        chk("tp_emits", n_emit - emit0, 1000);

`ifdef KS_PG_SUB_EN
        bus.in_sub = 1'b1;
        send(32'd5, 32'd3, 1'b0);
        bus.in_sub   = 1'b0;
        bus.in_valid = 1'b0;
        chk("sub_p", bus.p_list0, 32'hFFFF_FFF9);
        chk("sub_cin_q", bus.cin_q, 1);
        chk("sub_sum", pg_sum(bus.p_list0, bus.g_list0, bus.cin_q), 32'd2);
        tick(1);
`endif

        // counter wrap on the narrow-counter instance
        bus4.in_valid = 1'b1;
        repeat (17) @(posedge clk);
        #1;
        bus4.in_valid = 1'b0;
        chk("wrap_cnt", bus4.op_count, 1);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

endmodule
